// File: rtl/prospect_sensor.sv
// prospect_sensor
//   Companion block for the Stoplight FSM on the Prospect Ave approach.
//   - Debounces the raw inductive-loop input (sample flop + hold counter).
//   - Latches a car request until Prospect turns green; counts accepted arrivals.
//   - Sticky safety monitor over both light buses, recording the first fault cause.
// Ports
//   i_clk          system clock, all state on posedge
//   i_rst          synchronous active-high reset
//   i_loop_raw     raw loop sensor, 1 = metal over loop
//   i_light_pros   Prospect light, one-hot {G,Y,R} = bits {2,1,0}
//   i_light_wash   Washington light, same encoding
//   o_car_present  registered request to the Stoplight FSM
//   o_car_count    saturating count of accepted arrivals
//   o_fault        sticky safety violation flag
//   o_fault_code   first fault cause: 01 bad encoding, 10 conflict, 11 skipped yellow
module prospect_sensor #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_loop_raw,
  input  logic [2:0]       i_light_pros,
  input  logic [2:0]       i_light_wash,
  output logic             o_car_present,
  output logic [CNT_W-1:0] o_car_count,
  output logic             o_fault,
  output logic [1:0]       o_fault_code
);

  localparam int unsigned      DebW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DebW-1:0]  DebLast = DebW'(DEBOUNCE - 1);

  localparam logic [2:0] Red = 3'b001;
  localparam logic [2:0] Ylw = 3'b010;
  localparam logic [2:0] Grn = 3'b100;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StReq    = 2'b01,
    StServed = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic            r_loop_q;
  logic            r_loop_stable;
  logic [DebW-1:0] r_deb_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_loop_q      <= 1'b0;
      r_loop_stable <= 1'b0;
      r_deb_cnt     <= '0;
    end else begin
      r_loop_q <= i_loop_raw;
      if (r_loop_q == r_loop_stable) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DebLast) begin
        r_loop_stable <= r_loop_q;
        r_deb_cnt     <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DebW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Car counter: one count per rising edge of the debounced level
  // ---------------------------------------------------------------------------
  logic             r_stable_d;
  logic [CNT_W-1:0] r_car_count;
  logic             w_arrival;
  logic             w_cnt_max;

  assign w_arrival = r_loop_stable & ~r_stable_d;
  assign w_cnt_max = &r_car_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stable_d  <= 1'b0;
      r_car_count <= '0;
    end else begin
      r_stable_d <= r_loop_stable;
      if (w_arrival && !w_cnt_max) begin
        r_car_count <= r_car_count + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM (Moore, car_present registered alongside the state)
  // ---------------------------------------------------------------------------
  state_e r_state;
  logic   r_car_present;
  logic   w_pros_grn;

  assign w_pros_grn = (i_light_pros == Grn);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_car_present <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          // A car arriving on green simply drives through; no request.
          if (r_loop_stable && !w_pros_grn) begin
            r_state       <= StReq;
            r_car_present <= 1'b1;
          end
        end
        StReq: begin
          // Request stays latched even if the car leaves the loop.
          if (w_pros_grn) begin
            r_state       <= StServed;
            r_car_present <= 1'b0;
          end
        end
        StServed: begin
          if (!w_pros_grn) begin
            if (r_loop_stable) begin
              r_state       <= StReq;
              r_car_present <= 1'b1;
            end else begin
              r_state       <= StIdle;
              r_car_present <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= StIdle;
          r_car_present <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Safety monitor
  // ---------------------------------------------------------------------------
  logic [2:0] r_prev_pros;
  logic [2:0] r_prev_wash;
  logic       r_fault;
  logic [1:0] r_fault_code;
  logic       w_pros_ok;
  logic       w_wash_ok;
  logic       w_bad_enc;
  logic       w_conflict;
  logic       w_skip;
  logic [1:0] w_cause;

  assign w_pros_ok  = (i_light_pros == Red) || (i_light_pros == Ylw) || (i_light_pros == Grn);
  assign w_wash_ok  = (i_light_wash == Red) || (i_light_wash == Ylw) || (i_light_wash == Grn);
  assign w_bad_enc  = !w_pros_ok || !w_wash_ok;
  assign w_conflict = (i_light_pros != Red) && (i_light_wash != Red);
  assign w_skip     = ((r_prev_pros == Grn) && (i_light_pros == Red)) ||
                      ((r_prev_wash == Grn) && (i_light_wash == Red));

  // Priority when several causes coincide: encoding > conflict > skipped yellow.
  always_comb begin
    w_cause = 2'b11;
    if (w_bad_enc) begin
      w_cause = 2'b01;
    end else if (w_conflict) begin
      w_cause = 2'b10;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev_pros  <= Red;
      r_prev_wash  <= Red;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
    end else begin
      r_prev_pros <= i_light_pros;
      r_prev_wash <= i_light_wash;
      // Only the first violation is recorded; the flag is sticky until reset.
      if (!r_fault && (w_bad_enc || w_conflict || w_skip)) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_cause;
      end
    end
  end

  assign o_car_present = r_car_present;
  assign o_car_count   = r_car_count;
  assign o_fault       = r_fault;
  assign o_fault_code  = r_fault_code;

endmodule
